// File: rtl/state_loader.sv
// Collects a 5x5 block of 64-bit lanes (x-fastest) and hands it to the encoder with a start pulse.
// start_enc one cycle after the 25th accept; in_ready drops from launch until enc_ready is seen in WAIT.
module state_loader #(
    parameter int LANES  = 25,
    parameter int LANE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LANE_W-1:0] in_data,
    output logic              in_ready,
    input  logic [2:0]        rd_x,
    input  logic [2:0]        rd_y,
    output logic [LANE_W-1:0] rd_lane,
    output logic              start_enc,
    input  logic              enc_ready,
    output logic              busy,
    output logic [7:0]        blk_cnt
);
    localparam int CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, FILL, LAUNCH, WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        blk_cnt_q, blk_cnt_d;
    logic [LANE_W-1:0] lane_q [LANES];
    logic [LANE_W-1:0] lane_d [LANES];
    logic              accept;
    logic [CNT_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  rd_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_cnt_d = blk_cnt_q;
        lane_d    = lane_q;
        in_ready  = (state_q == IDLE) || (state_q == FILL);
        accept    = in_valid && in_ready;
        // IDLE always starts a fresh block at index 0
        wr_idx    = (state_q == IDLE) ? '0 : cnt_q;

        if (accept) begin
            lane_d[wr_idx] = in_data;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FILL;
                    cnt_d   = CNT_W'(1);
                end
            end
            FILL: begin
                if (accept) begin
                    if (cnt_q == LAST) begin
                        state_d = LAUNCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LAUNCH: begin
                state_d   = WAIT;
                blk_cnt_d = blk_cnt_q + 8'd1;
            end
            WAIT: begin
                if (enc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            blk_cnt_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blk_cnt_q <= blk_cnt_d;
            lane_q    <= lane_d;
        end
    end

    // rd_idx is only meaningful when both coordinates are inside the 5x5 grid
    assign rd_idx    = CNT_W'(rd_x) + CNT_W'(rd_y) * CNT_W'(5);
    assign rd_lane   = ((rd_x < 3'd5) && (rd_y < 3'd5)) ? lane_q[rd_idx] : '0;
    assign start_enc = (state_q == LAUNCH);
    assign busy      = (state_q != IDLE);
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_state_loader.sv
// Directed bench for state_loader: lanes are queued as they are driven and
// moved into a lane model when the block launches, then read back through rd_x/rd_y.
module tb_state_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic [2:0]  rd_x = '0;
    logic [2:0]  rd_y = '0;
    logic [63:0] rd_lane;
    logic        start_enc;
    logic        enc_ready = 1'b0;
    logic        busy;
    logic [7:0]  blk_cnt;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] sb [$];
    logic [63:0] exp_lane [25];
    logic [7:0]  exp_blk = '0;

    state_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_lane   (rd_lane),
        .start_enc (start_enc),
        .enc_ready (enc_ready),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drives one lane; returns 1ns after the accepting edge.
    task automatic push_lane(input logic [63:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        sb.push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_lanes(input string tag);
        for (int i = 0; i < 25; i++) begin
            rd_x = 3'(i % 5);
            rd_y = 3'(i / 5);
            #1;
            check($sformatf("%s_lane%0d", tag, i), rd_lane, exp_lane[i]);
        end
    endtask

    // Entered 1ns after the 25th accept, i.e. during the LAUNCH cycle.
    task automatic launch_phase(input string tag, input bit full, input bit enc_in_launch);
        if (full) begin
            check({tag, "_start_lat"}, 64'(start_enc), 64'd1);
            check({tag, "_launch_rdy"}, 64'(in_ready), 64'd0);
            check({tag, "_launch_busy"}, 64'(busy), 64'd1);
        end
        enc_ready = enc_in_launch;
        @(posedge clk);
        #1;
        enc_ready = 1'b0;
        exp_blk = exp_blk + 8'd1;
        if (full) begin
            check({tag, "_start_1cyc"}, 64'(start_enc), 64'd0);
            check({tag, "_sb_size"}, 64'(sb.size()), 64'd25);
        end
        check({tag, "_blk_cnt"}, 64'(blk_cnt), 64'(exp_blk));
        for (int i = 0; i < 25; i++) begin
            exp_lane[i] = sb.pop_front();
        end
    endtask

    task automatic release_block(input string tag);
        @(negedge clk);
        enc_ready = 1'b1;
        @(posedge clk);
        #1;
        enc_ready = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(start_enc), 64'd0);
        check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        check("rst_rd_lane", rd_lane, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back block with lane i = i
        for (int i = 0; i < 25; i++) push_lane(64'(i));
        launch_phase("b1", 1'b1, 1'b0);
        rd_x = 3'd3;
        rd_y = 3'd2;
        #1;
        check("b1_x3y2", rd_lane, 64'd13);
        check_lanes("b1");

        // Writes attempted in WAIT must be ignored
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        #1;
        check("wait_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("wait_busy", 64'(busy), 64'd1);
        check_lanes("wait_hold");
        release_block("b1");

        // Upstream stall after lane 7, with enc_ready pulsed during FILL
        for (int i = 0; i < 8; i++) push_lane(64'h100 + 64'(i));
        enc_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        enc_ready = 1'b0;
        check("stall_start", 64'(start_enc), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_rdy", 64'(in_ready), 64'd1);
        for (int i = 8; i < 25; i++) push_lane(64'h100 + 64'(i));
        launch_phase("b2", 1'b1, 1'b0);
        check_lanes("b2");
        release_block("b2");

        // enc_ready only during LAUNCH must not finish the block
        for (int i = 0; i < 25; i++) push_lane(64'h200 + 64'(i));
        launch_phase("b3", 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("b3_still_wait", 64'(busy), 64'd1);
        check("b3_wait_rdy", 64'(in_ready), 64'd0);
        check_lanes("b3");
        release_block("b3");

        // Reset in the middle of a fill, lane counter at 12
        for (int i = 0; i < 12; i++) push_lane(64'h300 + 64'(i));
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_start", 64'(start_enc), 64'd0);
        check("mid_rst_blk", 64'(blk_cnt), 64'd0);
        check("mid_rst_rdy", 64'(in_ready), 64'd1);
        sb.delete();
        exp_blk = '0;
        for (int i = 0; i < 25; i++) exp_lane[i] = '0;
        check_lanes("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) push_lane(64'h400 + 64'(i));
        launch_phase("b4", 1'b1, 1'b0);
        check_lanes("b4");
        release_block("b4");

        // 255 more blocks: blk_cnt wraps back to 0
        for (int b = 1; b < 256; b++) begin
            for (int i = 0; i < 25; i++) push_lane((64'(b) << 8) | 64'(i));
            launch_phase($sformatf("wrap%0d", b), 1'b0, 1'b0);
            if (b < 255) release_block($sformatf("wrap%0d", b));
        end
        check("wrap_blk_zero", 64'(blk_cnt), 64'd0);
        check_lanes("last_blk");
        release_block("last_blk");

        // Out-of-grid reads return zero
        rd_x = 3'd5;
        rd_y = 3'd0;
        #1;
        check("rd_x5", rd_lane, 64'd0);
        rd_x = 3'd0;
        rd_y = 3'd7;
        #1;
        check("rd_y7", rd_lane, 64'd0);
        rd_x = 3'd7;
        rd_y = 3'd7;
        #1;
        check("rd_x7y7", rd_lane, 64'd0);
        rd_x = 3'd4;
        rd_y = 3'd4;
        #1;
        check("rd_x4y4", rd_lane, (64'd255 << 8) | 64'd24);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/state_loader.md
STATE_LOADER -- requirements
Module: state_loader

Interface
REQ-001 LANES, 25, number of 64-bit lanes per state block.
REQ-002 LANE_W, 64, lane width in bits.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream lane valid.
REQ-006 in_data  input  64  lane data from the file reader.
REQ-007 in_ready  output  1  loader accepts a lane this cycle.
REQ-008 rd_x  input  3  column index requested by the encoder datapath.
REQ-009 rd_y  input  3  row index requested by the encoder datapath.
REQ-010 rd_lane  output  64  lane at (rd_x, rd_y), combinational.
REQ-011 start_enc  output  1  one-cycle pulse: state block complete, encoder may start.
REQ-012 enc_ready  input  1  encoder finished the current block; ready pulse from the encoder controller.
REQ-013 busy  output  1  high from first accepted lane until enc_ready is received.
REQ-014 blk_cnt  output  8  number of blocks handed to the encoder, modulo 256.

Function
REQ-015 The block SHALL implement FSM states IDLE, FILL, LAUNCH and WAIT.
REQ-016 IDLE: in_ready=1; an accepted lane (in_valid & in_ready) SHALL be stored at index 0 and move the FSM to FILL with lane counter=1.
REQ-017 FILL: in_ready=1; each accepted lane SHALL be stored at index = lane counter, and the counter SHALL increment by 1.
REQ-018 Lane index i SHALL map to x = i mod 5, y = i div 5, with order x-fastest.
REQ-019 Acceptance of lane 24 SHALL move FILL to LAUNCH on the same edge, with the counter reset to 0.
REQ-020 LAUNCH SHALL last exactly one cycle with start_enc=1 and in_ready=0; blk_cnt SHALL increment on leaving LAUNCH; next state is WAIT.
REQ-021 WAIT: in_ready=0; stored lanes SHALL be held unchanged; enc_ready=1 SHALL move the FSM to IDLE on the next edge.
REQ-022 Latency: start_enc SHALL assert in the cycle immediately after the edge that accepts lane 24.
REQ-023 Upstream stalls (in_valid=0 in FILL) SHALL hold the counter and the lanes; there is no timeout.
REQ-024 in_valid while in_ready=0 SHALL be ignored; no lane is written and the counter does not change.
REQ-025 enc_ready in IDLE, FILL or LAUNCH SHALL be ignored.
REQ-026 enc_ready asserted in the same cycle as the LAUNCH pulse SHALL NOT complete the block; only enc_ready sampled in WAIT counts.
REQ-027 rd_lane SHALL equal lane[rd_x + 5*rd_y] when rd_x<5 and rd_y<5, and SHALL be 0 otherwise.
REQ-028 rd_lane SHALL be valid in all states; the encoder SHALL read only in WAIT.
REQ-029 busy SHALL be 1 in FILL, LAUNCH and WAIT, and 0 in IDLE.
REQ-030 blk_cnt SHALL wrap from 255 to 0 without a flag.
REQ-031 A new block's lanes SHALL overwrite the previous block's lanes index by index; no clearing between blocks.

Reset
REQ-032 rst=1 SHALL force, asynchronously: FSM=IDLE, lane counter=0, blk_cnt=0, all 25 lanes=0, start_enc=0, busy=0.
REQ-033 While rst=1, in_ready SHALL read 1, because the FSM is IDLE.
REQ-034 Reset mid-FILL or mid-WAIT SHALL discard the partial or current block; the first lane after release is index 0.

Verification
REQ-035 Load lanes 64'h0..64'd24 back-to-back from IDLE -> start_enc pulses 1 cycle after the 25th accept; rd_x=3,rd_y=2 gives 64'd13; blk_cnt=1.
REQ-036 Drop in_valid for 10 cycles after lane 7 -> counter holds at 8, no start_enc; resuming completes the block with the correct lane order.
REQ-037 In WAIT, drive in_valid=1 with 64'hDEAD -> in_ready=0, lanes unchanged; enc_ready=1 -> IDLE next cycle, busy=0.
REQ-038 Assert enc_ready during LAUNCH only -> FSM stays in WAIT until enc_ready is re-asserted.
REQ-039 Assert rst during FILL at lane 12 -> all outputs/lanes zero; next 25 lanes form a full block; blk_cnt=1.
REQ-040 Run 256 blocks -> blk_cnt returns to 0; rd_x=5 or rd_y=7 -> rd_lane=0.
